// File: rtl/game_flow_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl_param_if
// Phase handshake bundle between the game sequencer and its surroundings
// (title screen, VGA drawing controller, datapath controller).
//   master : drives the done/level inputs, observes the phase strobes
//   slave  : the sequencer itself
// Signals:
//   start_display_done, begin_done, tower_done, car_done, end_display_done,
//   life_lost_in, pause_req, restart           -> into the sequencer
//   wait_start .. game_over_out (one-hot), stage_idx[3:0], lives_left[3:0],
//   timeout_flag                               <- from the sequencer
// ---------------------------------------------------------------------------
interface game_flow_ctrl_param_if;
    logic       start_display_done;
    logic       begin_done;
    logic       tower_done;
    logic       car_done;
    logic       end_display_done;
    logic       life_lost_in;
    logic       pause_req;
    logic       restart;

    logic       wait_start;
    logic       stage_begin;
    logic       draw_tower;
    logic       in_progress;
    logic       stage_done;
    logic       life_lost;
    logic       paused;
    logic       win;
    logic       game_over_out;
    logic [3:0] stage_idx;
    logic [3:0] lives_left;
    logic       timeout_flag;

    modport master (
        output start_display_done, begin_done, tower_done, car_done,
               end_display_done, life_lost_in, pause_req, restart,
        input  wait_start, stage_begin, draw_tower, in_progress, stage_done,
               life_lost, paused, win, game_over_out, stage_idx, lives_left,
               timeout_flag
    );

    modport slave (
        input  start_display_done, begin_done, tower_done, car_done,
               end_display_done, life_lost_in, pause_req, restart,
        output wait_start, stage_begin, draw_tower, in_progress, stage_done,
               life_lost, paused, win, game_over_out, stage_idx, lives_left,
               timeout_flag
    );
endinterface

// File: rtl/game_flow_ctrl_param.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl_param
// Parametrised game sequencer: walks NUM_STAGES stages through
// begin -> draw-tower -> in-progress -> stage-done, with a lives budget
// (stage retry on life loss), pause while in play, an optional per-phase
// watchdog that forces a stuck draw/display phase forward, and restart
// from WIN / GAME_OVER.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : game_flow_ctrl_param_if.slave (handshakes in, strobes out)
// Outputs are Moore: decoded only from registered state/counters.
// ---------------------------------------------------------------------------
module game_flow_ctrl_param #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned TIMEOUT    = 0,
    parameter int unsigned TMO_W      = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    game_flow_ctrl_param_if.slave  bus
);

    typedef enum logic [3:0] {
        S_WAIT_START  = 4'd0,
        S_BEGIN       = 4'd1,
        S_DRAW_TOWER  = 4'd2,
        S_IN_PROGRESS = 4'd3,
        S_PAUSED      = 4'd4,
        S_STAGE_DONE  = 4'd5,
        S_LIFE_LOST   = 4'd6,
        S_WIN         = 4'd7,
        S_GAME_OVER   = 4'd8
    } state_t;

    localparam logic [3:0]       LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [3:0]       LIVES_INIT = 4'(LIVES);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [3:0]         stage_q, stage_d;
    logic [3:0]         lives_q, lives_d;
    logic [TMO_W-1:0]   wd_q, wd_d;
    logic               tflag_q, tflag_d;

    logic               wd_active;
    logic               done_exp;
    logic               expire;
    logic               advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT_START;
            stage_q <= '0;
            lives_q <= LIVES_INIT;
            wd_q    <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            lives_q <= lives_d;
            wd_q    <= wd_d;
            tflag_q <= tflag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        lives_d   = lives_q;
        tflag_d   = tflag_q;
        wd_active = 1'b0;
        done_exp  = 1'b0;

        // Which done the watched phases are waiting for.
        case (state_q)
            S_BEGIN:      begin wd_active = 1'b1; done_exp = bus.begin_done;       end
            S_DRAW_TOWER: begin wd_active = 1'b1; done_exp = bus.tower_done;       end
            S_STAGE_DONE: begin wd_active = 1'b1; done_exp = bus.end_display_done; end
            S_LIFE_LOST:  begin wd_active = 1'b1; done_exp = bus.end_display_done; end
            default:      begin wd_active = 1'b0; done_exp = 1'b0;                 end
        endcase

        expire  = (TIMEOUT != 0) && wd_active && (wd_q == TMO_LAST);
        advance = done_exp || expire;

        // Only a forced advance marks the flag; a real done on the expiry
        // cycle counts as a normal completion.
        if (expire && !done_exp) begin
            tflag_d = 1'b1;
        end

        case (state_q)
            S_WAIT_START: begin
                if (bus.start_display_done) state_d = S_BEGIN;
            end
            S_BEGIN: begin
                if (advance) state_d = S_DRAW_TOWER;
            end
            S_DRAW_TOWER: begin
                if (advance) state_d = S_IN_PROGRESS;
            end
            S_IN_PROGRESS: begin
                if (bus.car_done) begin
                    state_d = S_STAGE_DONE;
                end else if (bus.life_lost_in) begin
                    if (lives_q <= 4'd1) begin
                        state_d = S_GAME_OVER;
                        lives_d = '0;
                    end else begin
                        state_d = S_LIFE_LOST;
                        lives_d = lives_q - 4'd1;
                    end
                end else if (bus.pause_req) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!bus.pause_req) state_d = S_IN_PROGRESS;
            end
            S_STAGE_DONE: begin
                if (advance) begin
                    if (stage_q >= LAST_STAGE) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_BEGIN;
                        stage_d = stage_q + 4'd1;
                    end
                end
            end
            S_LIFE_LOST: begin
                if (advance) state_d = S_BEGIN;
            end
            S_WIN, S_GAME_OVER: begin
                if (bus.restart) begin
                    state_d = S_WAIT_START;
                    stage_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            default: begin
                state_d = S_WAIT_START;
                stage_d = '0;
                lives_d = LIVES_INIT;
            end
        endcase

        // Counter measures time spent in the current watched phase.
        if ((state_d != state_q) || !wd_active) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + TMO_W'(1);
        end
    end

    assign bus.wait_start    = (state_q == S_WAIT_START);
    assign bus.stage_begin   = (state_q == S_BEGIN);
    assign bus.draw_tower    = (state_q == S_DRAW_TOWER);
    assign bus.in_progress   = (state_q == S_IN_PROGRESS);
    assign bus.paused        = (state_q == S_PAUSED);
    assign bus.stage_done    = (state_q == S_STAGE_DONE);
    assign bus.life_lost     = (state_q == S_LIFE_LOST);
    assign bus.win           = (state_q == S_WIN);
    assign bus.game_over_out = (state_q == S_GAME_OVER);
    assign bus.stage_idx     = stage_q;
    assign bus.lives_left    = lives_q;
    assign bus.timeout_flag  = tflag_q;

endmodule

// File: tb/tb_game_flow_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl_param
// Two sequencers share one stimulus stream:
//   dut_a : NUM_STAGES=3, LIVES=3, TIMEOUT=0  (watchdog disabled)
//   dut_b : NUM_STAGES=3, LIVES=1, TIMEOUT=16
// A phase-level model of each game is stepped on every clock and compared
// against the DUT outputs on every falling edge; directed scenarios add
// literal expectations.
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl_param;

    localparam int NS    = 3;
    localparam int LV_A  = 3;
    localparam int TMO_A = 0;
    localparam int LV_B  = 1;
    localparam int TMO_B = 16;

    // Phase numbering of the model: index of the strobe, wait_start first.
    localparam int PH_WAIT = 0, PH_BEGIN = 1, PH_DRAW = 2, PH_PLAY = 3,
                   PH_PAUSE = 4, PH_SDONE = 5, PH_LLOST = 6, PH_WIN = 7,
                   PH_OVER = 8;

    // Input bits of in_v.
    localparam int I_SDD = 0, I_BD = 1, I_TD = 2, I_CD = 3, I_EDD = 4,
                   I_LL = 5, I_PR = 6, I_RS = 7;

    typedef struct packed {
        logic [3:0]  ph;
        logic [3:0]  stage;
        logic [3:0]  lives;
        logic [31:0] cnt;     // cycles spent in the current phase
        logic        tflag;
    } mst_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_v;
    logic       chk_en;
    int         checks = 0;
    int         failures = 0;
    mst_t       ma, mb;

    game_flow_ctrl_param_if ifa ();
    game_flow_ctrl_param_if ifb ();

    assign ifa.start_display_done = in_v[I_SDD];
    assign ifa.begin_done         = in_v[I_BD];
    assign ifa.tower_done         = in_v[I_TD];
    assign ifa.car_done           = in_v[I_CD];
    assign ifa.end_display_done   = in_v[I_EDD];
    assign ifa.life_lost_in       = in_v[I_LL];
    assign ifa.pause_req          = in_v[I_PR];
    assign ifa.restart            = in_v[I_RS];
    assign ifb.start_display_done = in_v[I_SDD];
    assign ifb.begin_done         = in_v[I_BD];
    assign ifb.tower_done         = in_v[I_TD];
    assign ifb.car_done           = in_v[I_CD];
    assign ifb.end_display_done   = in_v[I_EDD];
    assign ifb.life_lost_in       = in_v[I_LL];
    assign ifb.pause_req          = in_v[I_PR];
    assign ifb.restart            = in_v[I_RS];

    game_flow_ctrl_param #(.NUM_STAGES(NS), .LIVES(LV_A), .TIMEOUT(TMO_A), .TMO_W(24))
        dut_a (.clk(clk), .reset(rst), .bus(ifa));
    game_flow_ctrl_param #(.NUM_STAGES(NS), .LIVES(LV_B), .TIMEOUT(TMO_B), .TMO_W(24))
        dut_b (.clk(clk), .reset(rst), .bus(ifb));

    always #5 clk = ~clk;

    logic [8:0] a_strb, b_strb;
    assign a_strb = {ifa.wait_start, ifa.stage_begin, ifa.draw_tower, ifa.in_progress,
                     ifa.paused, ifa.stage_done, ifa.life_lost, ifa.win, ifa.game_over_out};
    assign b_strb = {ifb.wait_start, ifb.stage_begin, ifb.draw_tower, ifb.in_progress,
                     ifb.paused, ifb.stage_done, ifb.life_lost, ifb.win, ifb.game_over_out};

    // ---------------- model ----------------
    function automatic mst_t mreset(input int lv);
        mst_t m;
        m.ph = 4'(PH_WAIT); m.stage = '0; m.lives = 4'(lv); m.cnt = '0; m.tflag = 1'b0;
        return m;
    endfunction

    function automatic mst_t step(input mst_t m, input logic [7:0] iv,
                                  input int ns, input int lv, input int tmo);
        mst_t n;
        bit   late;
        bit   got;
        n    = m;
        late = (tmo != 0) && (int'(m.cnt) == tmo - 1);
        got  = 1'b0;
        case (int'(m.ph))
            PH_WAIT:  if (iv[I_SDD]) n.ph = 4'(PH_BEGIN);
            PH_BEGIN: begin got = iv[I_BD]; if (got || late) n.ph = 4'(PH_DRAW); end
            PH_DRAW:  begin got = iv[I_TD]; if (got || late) n.ph = 4'(PH_PLAY); end
            PH_PLAY: begin
                if (iv[I_CD]) n.ph = 4'(PH_SDONE);
                else if (iv[I_LL]) begin
                    if (m.lives <= 1) begin n.ph = 4'(PH_OVER); n.lives = 0; end
                    else begin n.ph = 4'(PH_LLOST); n.lives = m.lives - 1; end
                end else if (iv[I_PR]) n.ph = 4'(PH_PAUSE);
            end
            PH_PAUSE: if (!iv[I_PR]) n.ph = 4'(PH_PLAY);
            PH_SDONE: begin
                got = iv[I_EDD];
                if (got || late) begin
                    if (int'(m.stage) == ns - 1) n.ph = 4'(PH_WIN);
                    else begin n.ph = 4'(PH_BEGIN); n.stage = m.stage + 1; end
                end
            end
            PH_LLOST: begin got = iv[I_EDD]; if (got || late) n.ph = 4'(PH_BEGIN); end
            default: if (iv[I_RS]) begin n.ph = 4'(PH_WAIT); n.stage = 0; n.lives = 4'(lv); end
        endcase
        if ((m.ph == 4'(PH_BEGIN) || m.ph == 4'(PH_DRAW) || m.ph == 4'(PH_SDONE) ||
             m.ph == 4'(PH_LLOST)) && late && !got)
            n.tflag = 1'b1;
        n.cnt = (n.ph == m.ph) ? m.cnt + 1 : 0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mreset(LV_A);
            mb <= mreset(LV_B);
        end else begin
            ma <= step(ma, in_v, NS, LV_A, TMO_A);
            mb <= step(mb, in_v, NS, LV_B, TMO_B);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] onehot(input logic [3:0] ph);
        logic [8:0] top;
        top = 9'h100;
        return top >> ph;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_strobes", 32'(a_strb), 32'(onehot(ma.ph)));
            chk("a_stage",   32'(ifa.stage_idx), 32'(ma.stage));
            chk("a_lives",   32'(ifa.lives_left), 32'(ma.lives));
            chk("a_tflag",   32'(ifa.timeout_flag), 32'(ma.tflag));
            chk("b_strobes", 32'(b_strb), 32'(onehot(mb.ph)));
            chk("b_stage",   32'(ifb.stage_idx), 32'(mb.stage));
            chk("b_lives",   32'(ifb.lives_left), 32'(mb.lives));
            chk("b_tflag",   32'(ifb.timeout_flag), 32'(mb.tflag));
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic pulse(input int b);
        in_v[b] = 1'b1;
        @(negedge clk);
        in_v[b] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        in_v = '0;
        rst  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    bit lowp;
    int p;

    initial begin
        in_v   = '0;
        rst    = 1'b0;
        chk_en = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset values.
        chk("rst_a_wait",  32'(ifa.wait_start), 1);
        chk("rst_a_stage", 32'(ifa.stage_idx), 0);
        chk("rst_a_lives", 32'(ifa.lives_left), 3);
        chk("rst_b_lives", 32'(ifb.lives_left), 1);

        // Full game, all three stages.
        pulse(I_SDD);
        chk("s1_begin", 32'(ifa.stage_begin), 1);
        for (int s = 0; s < NS; s++) begin
            pulse(I_BD);
            pulse(I_TD);
            chk("s1_stage", 32'(ifa.stage_idx), 32'(s));
            chk("s1_play",  32'(ifa.in_progress), 1);
            pulse(I_CD);
            pulse(I_EDD);
        end
        chk("s1_win",   32'(ifa.win), 1);
        chk("s1_stage2", 32'(ifa.stage_idx), 2);
        chk("s1_lives", 32'(ifa.lives_left), 3);
        idle(3);
        chk("s1_win_hold", 32'(ifa.win), 1);
        chk("s1_b_win", 32'(ifb.win), 1);
        pulse(I_RS);
        chk("s1_restart", 32'(ifa.wait_start), 1);

        // Life lost in stage 1: retry for a, game over for b (one life).
        do_reset();
        pulse(I_SDD);
        pulse(I_BD); pulse(I_TD); pulse(I_CD); pulse(I_EDD);
        pulse(I_BD); pulse(I_TD);
        chk("s2_play1", 32'(ifa.in_progress), 1);
        pulse(I_LL);
        chk("s2_a_llost", 32'(ifa.life_lost), 1);
        chk("s2_a_lives", 32'(ifa.lives_left), 2);
        chk("s2_b_over",  32'(ifb.game_over_out), 1);
        chk("s2_b_lives", 32'(ifb.lives_left), 0);
        chk("s2_model_b", 32'(mb.ph), PH_OVER);
        pulse(I_EDD);
        chk("s2_a_retry", 32'(ifa.stage_begin), 1);
        chk("s2_a_stage", 32'(ifa.stage_idx), 1);
        chk("s2_a_lives2", 32'(ifa.lives_left), 2);
        chk("s2_model_a", 32'(ma.lives), 2);
        pulse(I_RS);
        chk("s2_b_wait",  32'(ifb.wait_start), 1);
        chk("s2_b_stage", 32'(ifb.stage_idx), 0);
        chk("s2_b_relives", 32'(ifb.lives_left), 1);
        chk("s2_a_ign_rs", 32'(ifa.stage_begin), 1);

        // car_done beats life_lost_in; pause holds off car_done.
        do_reset();
        pulse(I_SDD); pulse(I_BD); pulse(I_TD);
        in_v[I_CD] = 1'b1; in_v[I_LL] = 1'b1;
        @(negedge clk);
        in_v[I_CD] = 1'b0; in_v[I_LL] = 1'b0;
        chk("s3_sdone", 32'(ifa.stage_done), 1);
        chk("s3_lives", 32'(ifa.lives_left), 3);
        pulse(I_EDD); pulse(I_BD); pulse(I_TD);
        in_v[I_PR] = 1'b1;
        @(negedge clk);
        chk("s3_paused", 32'(ifa.paused), 1);
        in_v[I_CD] = 1'b1;
        idle(9);
        chk("s3_paused_hold", 32'(ifa.paused), 1);
        in_v[I_PR] = 1'b0; in_v[I_CD] = 1'b0;
        @(negedge clk);
        chk("s3_resume", 32'(ifa.in_progress), 1);
        chk("s3_stage", 32'(ifa.stage_idx), 1);

        // Watchdog expiry in DRAW_TOWER (b only).
        do_reset();
        pulse(I_SDD); pulse(I_BD);
        idle(15);
        chk("s4_b_draw15", 32'(ifb.draw_tower), 1);
        idle(1);
        chk("s4_b_play16", 32'(ifb.in_progress), 1);
        chk("s4_b_tflag",  32'(ifb.timeout_flag), 1);
        chk("s4_a_draw",   32'(ifa.draw_tower), 1);
        chk("s4_a_tflag",  32'(ifa.timeout_flag), 0);
        // Real done on the expiry cycle.
        do_reset();
        pulse(I_SDD); pulse(I_BD);
        idle(15);
        pulse(I_TD);
        chk("s4_b_edge_play",  32'(ifb.in_progress), 1);
        chk("s4_b_edge_tflag", 32'(ifb.timeout_flag), 0);
        // Early done.
        do_reset();
        pulse(I_SDD); pulse(I_BD);
        idle(4);
        pulse(I_TD);
        chk("s4_b_early_tflag", 32'(ifb.timeout_flag), 0);

        // Asynchronous reset during stage 2 play.
        do_reset();
        pulse(I_SDD);
        for (int s = 0; s < 2; s++) begin
            pulse(I_BD); pulse(I_TD); pulse(I_CD); pulse(I_EDD);
        end
        pulse(I_BD); pulse(I_TD);
        chk("s5_stage2", 32'(ifa.stage_idx), 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("s5_a_wait",  32'(ifa.wait_start), 1);
        chk("s5_a_play",  32'(ifa.in_progress), 0);
        chk("s5_a_stage", 32'(ifa.stage_idx), 0);
        chk("s5_a_lives", 32'(ifa.lives_left), 3);
        @(negedge clk);
        rst = 1'b0;

        // Randomised play; alternating slow/fast done rates so the
        // watchdog of dut_b expires regularly.
        lowp = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (cyc % 400 == 0) lowp = !lowp;
            p = lowp ? 3 : 35;
            for (int b = 0; b < 5; b++) in_v[b] = ($urandom_range(99) < p);
            in_v[I_LL] = ($urandom_range(99) < 12);
            if ($urandom_range(99) < 10) in_v[I_PR] = ~in_v[I_PR];
            in_v[I_RS] = ($urandom_range(99) < 5);
            if ($urandom_range(499) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
